// File: rtl/division_datapath_if.sv
// rtl/division_datapath_if.sv - strobe/status/result bundle between division control FSM and datapath (listo under DIVISION_DATAPATH_DONE_EN)
interface division_datapath_if #(
    parameter int WIDTH = 8
);
    // Operand capture
    logic             load;
    logic [WIDTH-1:0] dividendo;
    logic [WIDTH-1:0] divisor;

    // Control strobes from the FSM
    logic [1:0]       salida;
    logic             bajar;
    logic             igualar;

    // Status back to the FSM
    logic             mayor;
    logic             termino;

    // Results
    logic [WIDTH-1:0] cociente;
    logic [WIDTH-1:0] residuo;
    logic             div_cero;
`ifdef DIVISION_DATAPATH_DONE_EN
    logic             listo;
`endif

    // Control side: drives operands and strobes, observes status and results
    modport master (
`ifdef DIVISION_DATAPATH_DONE_EN
        input  listo,
`endif
        output load, dividendo, divisor, salida, bajar, igualar,
        input  mayor, termino, cociente, residuo, div_cero
    );

    // Datapath side
    modport slave (
`ifdef DIVISION_DATAPATH_DONE_EN
        output listo,
`endif
        input  load, dividendo, divisor, salida, bajar, igualar,
        output mayor, termino, cociente, residuo, div_cero
    );
endinterface

// File: rtl/division_datapath.sv
// rtl/division_datapath.sv - restoring long-division datapath; optional listo pulse under DIVISION_DATAPATH_DONE_EN
module division_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    division_datapath_if.slave    dp
);

    localparam logic [1:0] SAL_ONE  = 2'b01;
    localparam logic [1:0] SAL_ZERO = 2'b10;

    // Dividend shift register: its MSB is the next bit brought down
    logic [WIDTH-1:0] d_q, d_d;
    // Divisor captured at load
    logic [WIDTH-1:0] v_q, v_d;
    // Partial remainder carries one extra bit so a shifted value up to 2*V-1 fits
    logic [WIDTH:0]   r_q, r_d;
    // Quotient shift register
    logic [WIDTH-1:0] q_q, q_d;
    // Remaining bring-down iterations
    logic [CNT_W-1:0] c_q, c_d;
    logic             div_cero_q, div_cero_d;

    logic             mayor_w;
    logic             termino_w;
    logic             shift_q_w;
    logic [WIDTH:0]   r_sub_w;

    assign mayor_w   = (r_q >= {1'b0, v_q});
    assign termino_w = (c_q == '0);
    assign shift_q_w = (dp.salida == SAL_ONE) || (dp.salida == SAL_ZERO);
    // Only ever used when mayor_w holds, so the difference never wraps
    assign r_sub_w   = r_q - {1'b0, v_q};

    // Next-state computation: load overrides everything, bajar beats igualar
    always_comb begin
        d_d        = d_q;
        v_d        = v_q;
        r_d        = r_q;
        q_d        = q_q;
        c_d        = c_q;
        div_cero_d = div_cero_q;

        if (dp.load) begin
            d_d        = dp.dividendo;
            v_d        = dp.divisor;
            r_d        = '0;
            q_d        = '0;
            c_d        = CNT_W'(WIDTH);
            div_cero_d = (dp.divisor == '0);
        end else begin
            if (dp.bajar) begin
                // A bring-down with the counter exhausted is a no-op, and it
                // still suppresses any igualar issued in the same cycle
                if (!termino_w) begin
                    r_d = {r_q[WIDTH-1:0], d_q[WIDTH-1]};
                    d_d = {d_q[WIDTH-2:0], 1'b0};
                    c_d = c_q - CNT_W'(1);
                end
            end else if (dp.igualar && mayor_w) begin
                r_d = r_sub_w;
            end

            if (dp.salida == SAL_ONE) begin
                q_d = {q_q[WIDTH-2:0], 1'b1};
            end else if (dp.salida == SAL_ZERO) begin
                q_d = {q_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q        <= '0;
            v_q        <= '0;
            r_q        <= '0;
            q_q        <= '0;
            c_q        <= '0;
            div_cero_q <= 1'b0;
        end else begin
            d_q        <= d_d;
            v_q        <= v_d;
            r_q        <= r_d;
            q_q        <= q_d;
            c_q        <= c_d;
            div_cero_q <= div_cero_d;
        end
    end

`ifdef DIVISION_DATAPATH_DONE_EN
    logic listo_q, listo_d;

    // Final quotient bit is the one shifted in after the last bring-down
    always_comb begin
        listo_d = 1'b0;
        if (!dp.load && shift_q_w && termino_w) begin
            listo_d = 1'b1;
        end
    end

    // Done pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            listo_q <= 1'b0;
        end else begin
            listo_q <= listo_d;
        end
    end

    assign dp.listo = listo_q;
`else
    logic unused_w;
    assign unused_w = shift_q_w;
`endif

    assign dp.mayor    = mayor_w;
    assign dp.termino  = termino_w;
    assign dp.cociente = q_q;
    assign dp.residuo  = r_q[WIDTH-1:0];
    assign dp.div_cero = div_cero_q;

endmodule

// File: tb/tb_division_datapath.sv
// tb/tb_division_datapath.sv - self-checking bench for division_datapath (listo checked when DIVISION_DATAPATH_DONE_EN is defined)
module tb_division_datapath;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   listo_cnt;

    division_datapath_if #(.WIDTH(WIDTH)) dif ();

    division_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
`ifdef DIVISION_DATAPATH_DONE_EN
        listo_cnt += int'(dif.listo);
`endif
    endtask

    task automatic idle_inputs();
        dif.load      = 1'b0;
        dif.salida    = 2'b00;
        dif.bajar     = 1'b0;
        dif.igualar   = 1'b0;
    endtask

    // Drives one complete (or truncated) long division like the control FSM would,
    // predicting every compare from plain arithmetic on the dividend prefix.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int n_iter, input string tag);
        int rem;
        int exp_q;
        int exp_r;
        logic exp_m;
        listo_cnt = 0;
        dif.load      = 1'b1;
        dif.dividendo = a;
        dif.divisor   = b;
        step();
        idle_inputs();
        dif.dividendo = $urandom_range(0, 255);
        dif.divisor   = $urandom_range(0, 255);
        n_checks++;
        if (dif.div_cero !== (b == 0)) $display("FAIL %s div_cero_after_load got %0d exp %0d", tag, dif.div_cero, (b == 0));
        else n_pass++;
        n_checks++;
        if (dif.termino !== 1'b0 || dif.cociente !== 8'd0 || dif.residuo !== 8'd0)
            $display("FAIL %s load_state got t=%0d q=%0d r=%0d exp t=0 q=0 r=0", tag, dif.termino, dif.cociente, dif.residuo);
        else n_pass++;

        rem = 0;
        for (int k = 0; k < n_iter; k++) begin
            dif.bajar = 1'b1;
            step();
            dif.bajar = 1'b0;
            rem   = rem * 2 + int'(a[7-k]);
            exp_m = (rem >= int'(b));
            n_checks++;
            if (dif.mayor !== exp_m) $display("FAIL %s mayor_iter%0d got %0d exp %0d", tag, k, dif.mayor, exp_m);
            else n_pass++;
            if (exp_m) begin
                dif.igualar = 1'b1;
                dif.salida  = 2'b01;
                rem = rem - int'(b);
            end else begin
                dif.salida  = 2'b10;
            end
            step();
            idle_inputs();
        end

        if (n_iter == 8) begin
            exp_q = (b == 0) ? 255 : int'(a) / int'(b);
            exp_r = (b == 0) ? int'(a) : int'(a) % int'(b);
            n_checks++;
            if (int'(dif.cociente) !== exp_q) $display("FAIL %s cociente got %0d exp %0d", tag, dif.cociente, exp_q);
            else n_pass++;
            n_checks++;
            if (int'(dif.residuo) !== exp_r) $display("FAIL %s residuo got %0d exp %0d", tag, dif.residuo, exp_r);
            else n_pass++;
            n_checks++;
            if (dif.termino !== 1'b1) $display("FAIL %s termino got %0d exp 1", tag, dif.termino);
            else n_pass++;
            n_checks++;
            if (dif.div_cero !== (b == 0)) $display("FAIL %s div_cero_end got %0d exp %0d", tag, dif.div_cero, (b == 0));
            else n_pass++;
`ifdef DIVISION_DATAPATH_DONE_EN
            n_checks++;
            if (listo_cnt !== 1) $display("FAIL %s listo_pulses got %0d exp 1", tag, listo_cnt);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        dif.dividendo = 8'd0;
        dif.divisor   = 8'd0;
        #2;
        n_checks++;
        if (dif.cociente !== 8'd0 || dif.residuo !== 8'd0 || dif.div_cero !== 1'b0)
            $display("FAIL reset_values got q=%0d r=%0d z=%0d exp 0 0 0", dif.cociente, dif.residuo, dif.div_cero);
        else n_pass++;
        n_checks++;
        if (dif.termino !== 1'b1 || dif.mayor !== 1'b1)
            $display("FAIL reset_flags got t=%0d m=%0d exp 1 1", dif.termino, dif.mayor);
        else n_pass++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_div(8'd13,  8'd3, 8, "d13_3");
        run_div(8'd255, 8'd1, 8, "d255_1");
        run_div(8'd7,   8'd9, 8, "d7_9");
        run_div(8'd200, 8'd0, 8, "d200_0");
        run_div(8'd10,  8'd2, 8, "d10_2");
    endtask

    task automatic test_async_reset();
        run_div(8'd100, 8'd7, 3, "ar_part");
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dif.cociente !== 8'd0 || dif.residuo !== 8'd0 || dif.div_cero !== 1'b0 || dif.termino !== 1'b1)
            $display("FAIL async_reset got q=%0d r=%0d z=%0d t=%0d exp 0 0 0 1",
                     dif.cociente, dif.residuo, dif.div_cero, dif.termino);
        else n_pass++;
        rst = 1'b0;
        run_div(8'd100, 8'd7, 8, "ar_full");
    endtask

    task automatic test_mid_load_and_stray();
        run_div(8'd100, 8'd7, 2, "ml_part");
        run_div(8'd50,  8'd5, 8, "ml_50_5");
        listo_cnt = 0;
        dif.bajar = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (dif.cociente !== 8'd10 || dif.residuo !== 8'd0 || dif.termino !== 1'b1)
            $display("FAIL stray_bajar got q=%0d r=%0d t=%0d exp 10 0 1", dif.cociente, dif.residuo, dif.termino);
        else n_pass++;
        n_checks++;
        if (dif.mayor !== 1'b0) $display("FAIL stray_mayor got %0d exp 0", dif.mayor);
        else n_pass++;
        dif.igualar = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (dif.cociente !== 8'd10 || dif.residuo !== 8'd0)
            $display("FAIL stray_igualar got q=%0d r=%0d exp 10 0", dif.cociente, dif.residuo);
        else n_pass++;
`ifdef DIVISION_DATAPATH_DONE_EN
        n_checks++;
        if (listo_cnt !== 0) $display("FAIL stray_listo got %0d exp 0", listo_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom_range(0, 255));
            b = (n % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            run_div(a, b, 8, "rand");
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        listo_cnt = 0;
        rst       = 1'b1;
        test_reset();
        test_directed();
        test_async_reset();
        test_mid_load_and_stray();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
